rename_commit_ctrl: RTL and testbench
=====================================

// Module: rename_commit_ctrl
// PURPOSE
//  Owns the active list; sequences in-order retirement and mispredict rollback for register renaming.
//  Sits between rename (alloc), writeback (done marking), free list (frees) and RMT (restores).
//  Commit returns old phys regs to the free list.
//  Rollback walks squashed entries youngest-first: restores RMT and frees new phys regs.
// PARAMETERS
//  AL_DEPTH  32                  active-list entries (power of 2)
//  PHYS_W    6                   physical register index width
//  ARCH_W    5                   architectural register index width
//  IDX_W     $clog2(AL_DEPTH)    tag / pointer index width
// PORTS
//  clk              in   1        clock
//  rst_n            in   1        reset, asynchronous, active-low
//  alloc_valid      in   1        rename requests an entry
//  alloc_ready      out  1        entry available (comb)
//  alloc_uses_rw    in   1        instr writes a dest reg
//  alloc_arch_rd    in   ARCH_W   dest arch reg
//  alloc_new_phys   in   PHYS_W   newly mapped phys reg
//  alloc_old_phys   in   PHYS_W   previous mapping of alloc_arch_rd
//  alloc_tag        out  IDX_W    tag of entry being allocated (= tail, comb)
//  wb_valid         in   1        writeback completed
//  wb_tag           in   IDX_W    tag of completed instr
//  flush_req        in   1        mispredict: squash all entries younger than flush_tag
//  flush_tag        in   IDX_W    tag of mispredicted branch (survives)
//  commit_valid     out  1        registered 1-cycle pulse: head retired
//  commit_arch_rd   out  ARCH_W   retired dest arch reg
//  commit_phys      out  PHYS_W   retired new phys reg (now architectural)
//  free_valid       out  1        registered pulse: return free_phys to free list
//  free_phys        out  PHYS_W   phys reg to free
//  restore_valid    out  1        registered pulse: write RMT[restore_arch_rd]=restore_phys
//  restore_arch_rd  out  ARCH_W   arch reg to restore
//  restore_phys     out  PHYS_W   old mapping to restore
//  recovering       out  1        FSM in WALK (registered)
//  al_count         out  IDX_W+1  occupied entries
// BEHAVIOUR
//  Reset: head=tail=0, count=0, all done/valid bits 0, state IDLE, all registered outputs 0.
//  Entry = {valid, done, uses_rw, arch_rd, new_phys, old_phys}; head/tail wrap modulo AL_DEPTH.
//  FSM IDLE:
//   - alloc_ready = IDLE & count<AL_DEPTH & !flush_req. Never depends on same-cycle commit.
//   - Accept writes entry at tail (done=0), tail++.
//  wb: sets done[wb_tag] at edge if entry valid; ignored for invalid/squashed tags. Legal in any state.
//  Commit (IDLE only, max 1/cycle):
//   - Fires if count>0 & done[head]; entry invalidated, head++.
//   - commit_valid high the cycle after the edge. wb in cycle t -> commit_valid in t+2 when head.
//   - free_valid/free_phys=old_phys only if uses_rw; commit_* driven regardless.
//  Same-cycle alloc+commit: both occur, count unchanged.
//  Empty: no commit. Full: alloc_ready=0.
//  Flush, sampled in IDLE with flush_tag a valid entry:
//   - Commit same cycle still allowed (walk never touches <=flush_tag).
//   - flush_tag==tail-1: nothing to squash; stay IDLE.
//   - Otherwise walk_ptr=tail-1 -> WALK.
//   - Invalid flush_tag: ignored. flush_req while WALK: ignored.
//  WALK, one entry per cycle:
//   - Invalidate entry[walk_ptr]; if uses_rw: restore(arch_rd,old_phys) + free(new_phys); walk_ptr--.
//   - On walk_ptr==flush_tag+1 processed: tail=flush_tag+1 -> IDLE.
//   - recovering=1 exactly during WALK cycles. No alloc or commit in WALK.
//  Restore/free pulses are never simultaneous with commit pulses (FSM exclusive).
//  rst_n low anytime (incl. mid-WALK): immediate clear to reset state.
// CONFIGURATION
//  RENAME_CMT_STATS_EN defined: adds outputs stat_commits[31:0], stat_squashed[31:0].
//   - Wrapping counters, +1 per commit / per walked entry; reset 0.
//  Undefined: those ports and counters do not exist; behaviour otherwise identical.
// TESTING
//  1 Reset -> alloc_ready=1, al_count=0, alloc_tag=0, every *_valid=0, recovering=0.
//  2 Alloc r1:p33/old p1, r2:p34/old p2, r3:p35/old p3 (tags 0,1,2); wb tag1 then tag0
//     -> commit tag0 (free p1) then tag1 (free p2) on consecutive cycles; al_count=1.
//  3 Alloc 32 w/o wb -> alloc_ready=0, al_count=32; wb tag0 -> one commit, then alloc_ready=1, alloc_tag=0.
//  4 Tags 0..4 allocated, flush_req tag=1 -> restore/free for tags 4,3,2 on 3 consecutive cycles
//     (restore_phys=old, free_phys=new); recovering=1 for 3 cycles; next alloc_tag=2, al_count=2.
//  5 Stream 40 alloc+wb -> tags wrap 31->0, commits strictly in alloc order, no lost/dup frees.
//  6 rst_n low mid-WALK -> recovering, all pulses, al_count to 0 asynchronously; resumes cleanly.

Source files
------------

// File: rtl/rename_commit_ctrl.sv
// Active-list controller for register renaming.
// Tracks in-flight renamed instructions in a circular active list, retires the
// head in order (returning its old physical register to the free list) and, on
// a mispredict, walks the squashed entries youngest-first, restoring the rename
// map and freeing their newly allocated physical registers.
// Optional build macro: RENAME_CMT_STATS_EN adds commit / squash event counters.
module rename_commit_ctrl #(
  parameter int unsigned AL_DEPTH = 32,
  parameter int unsigned PHYS_W   = 6,
  parameter int unsigned ARCH_W   = 5,
  parameter int unsigned IDX_W    = $clog2(AL_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  // Rename-side allocation
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_uses_rw_i,
  input  logic [ARCH_W-1:0] alloc_arch_rd_i,
  input  logic [PHYS_W-1:0] alloc_new_phys_i,
  input  logic [PHYS_W-1:0] alloc_old_phys_i,
  output logic [IDX_W-1:0]  alloc_tag_o,
  // Writeback completion
  input  logic              wb_valid_i,
  input  logic [IDX_W-1:0]  wb_tag_i,
  // Mispredict recovery request
  input  logic              flush_req_i,
  input  logic [IDX_W-1:0]  flush_tag_i,
  // Retirement
  output logic              commit_valid_o,
  output logic [ARCH_W-1:0] commit_arch_rd_o,
  output logic [PHYS_W-1:0] commit_phys_o,
  // Free list return
  output logic              free_valid_o,
  output logic [PHYS_W-1:0] free_phys_o,
  // Rename map restore
  output logic              restore_valid_o,
  output logic [ARCH_W-1:0] restore_arch_rd_o,
  output logic [PHYS_W-1:0] restore_phys_o,
  output logic              recovering_o,
  output logic [IDX_W:0]    al_count_o
`ifdef RENAME_CMT_STATS_EN
  ,
  output logic [31:0]       stat_commits_o,
  output logic [31:0]       stat_squashed_o
`endif
);

  localparam logic [IDX_W-1:0] IdxOne  = IDX_W'(1);
  localparam logic [IDX_W:0]   CntOne  = (IDX_W+1)'(1);
  localparam logic [IDX_W:0]   FullCnt = (IDX_W+1)'(AL_DEPTH);

  typedef enum logic [0:0] {StIdle, StWalk} state_e;

  state_e state_q, state_d;

  // Per-entry status bits (reset) and payload (written only on allocation).
  logic [AL_DEPTH-1:0] valid_q, valid_d;
  logic [AL_DEPTH-1:0] done_q, done_d;
  logic [AL_DEPTH-1:0] rw_q;
  logic [ARCH_W-1:0]   arch_q [AL_DEPTH];
  logic [PHYS_W-1:0]   newp_q [AL_DEPTH];
  logic [PHYS_W-1:0]   oldp_q [AL_DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] walk_q, walk_d;
  logic [IDX_W-1:0] ftag_q, ftag_d;
  logic [IDX_W:0]   count_q, count_d;

  logic              commit_valid_q, commit_valid_d;
  logic [ARCH_W-1:0] commit_arch_q, commit_arch_d;
  logic [PHYS_W-1:0] commit_phys_q, commit_phys_d;
  logic              free_valid_q, free_valid_d;
  logic [PHYS_W-1:0] free_phys_q, free_phys_d;
  logic              restore_valid_q, restore_valid_d;
  logic [ARCH_W-1:0] restore_arch_q, restore_arch_d;
  logic [PHYS_W-1:0] restore_phys_q, restore_phys_d;

  logic             idle;
  logic             alloc_fire;
  logic             commit_fire;
  logic             flush_start;
  logic [IDX_W-1:0] tail_m1;
  logic [IDX_W-1:0] ftag_p1;

  // Handshake and event decode for the current cycle.
  always_comb begin
    idle          = (state_q == StIdle);
    tail_m1       = tail_q - IdxOne;
    ftag_p1       = ftag_q + IdxOne;
    alloc_ready_o = idle && (count_q < FullCnt) && !flush_req_i;
    alloc_fire    = alloc_valid_i && alloc_ready_o;
    // done is only ever set on valid entries, so done[head] implies a live head.
    commit_fire   = idle && (count_q != '0) && done_q[head_q];
    // Flushing at the youngest entry squashes nothing, so no walk is needed.
    flush_start   = idle && flush_req_i && valid_q[flush_tag_i] && (flush_tag_i != tail_m1);
  end

  // Next-state for pointers, entry status, FSM and the registered pulse outputs.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    done_d          = done_q;
    head_d          = head_q;
    tail_d          = tail_q;
    walk_d          = walk_q;
    ftag_d          = ftag_q;
    count_d         = count_q;
    commit_valid_d  = 1'b0;
    commit_arch_d   = commit_arch_q;
    commit_phys_d   = commit_phys_q;
    free_valid_d    = 1'b0;
    free_phys_d     = free_phys_q;
    restore_valid_d = 1'b0;
    restore_arch_d  = restore_arch_q;
    restore_phys_d  = restore_phys_q;

    // Writeback to a squashed or empty slot is dropped.
    if (wb_valid_i && valid_q[wb_tag_i]) begin
      done_d[wb_tag_i] = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (alloc_fire) begin
          valid_d[tail_q] = 1'b1;
          done_d[tail_q]  = 1'b0;
          tail_d          = tail_q + IdxOne;
        end
        if (commit_fire) begin
          valid_d[head_q] = 1'b0;
          done_d[head_q]  = 1'b0;
          head_d          = head_q + IdxOne;
          commit_valid_d  = 1'b1;
          commit_arch_d   = arch_q[head_q];
          commit_phys_d   = newp_q[head_q];
          free_valid_d    = rw_q[head_q];
          if (rw_q[head_q]) begin
            free_phys_d = oldp_q[head_q];
          end
        end
        if (alloc_fire && !commit_fire) begin
          count_d = count_q + CntOne;
        end else if (!alloc_fire && commit_fire) begin
          count_d = count_q - CntOne;
        end
        if (flush_start) begin
          walk_d  = tail_m1;
          ftag_d  = flush_tag_i;
          state_d = StWalk;
        end
      end
      StWalk: begin
        valid_d[walk_q] = 1'b0;
        done_d[walk_q]  = 1'b0;
        count_d         = count_q - CntOne;
        restore_valid_d = rw_q[walk_q];
        free_valid_d    = rw_q[walk_q];
        if (rw_q[walk_q]) begin
          restore_arch_d = arch_q[walk_q];
          restore_phys_d = oldp_q[walk_q];
          free_phys_d    = newp_q[walk_q];
        end
        // The entry just above the surviving branch is the last one to undo.
        if (walk_q == ftag_p1) begin
          tail_d  = walk_q;
          state_d = StIdle;
        end else begin
          walk_d = walk_q - IdxOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      walk_q          <= '0;
      ftag_q          <= '0;
      count_q         <= '0;
      commit_valid_q  <= 1'b0;
      commit_arch_q   <= '0;
      commit_phys_q   <= '0;
      free_valid_q    <= 1'b0;
      free_phys_q     <= '0;
      restore_valid_q <= 1'b0;
      restore_arch_q  <= '0;
      restore_phys_q  <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      done_q          <= done_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      walk_q          <= walk_d;
      ftag_q          <= ftag_d;
      count_q         <= count_d;
      commit_valid_q  <= commit_valid_d;
      commit_arch_q   <= commit_arch_d;
      commit_phys_q   <= commit_phys_d;
      free_valid_q    <= free_valid_d;
      free_phys_q     <= free_phys_d;
      restore_valid_q <= restore_valid_d;
      restore_arch_q  <= restore_arch_d;
      restore_phys_q  <= restore_phys_d;
    end
  end

  // Entry payload; qualified by valid_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rw_q[tail_q]   <= alloc_uses_rw_i;
      arch_q[tail_q] <= alloc_arch_rd_i;
      newp_q[tail_q] <= alloc_new_phys_i;
      oldp_q[tail_q] <= alloc_old_phys_i;
    end
  end

`ifdef RENAME_CMT_STATS_EN
  logic [31:0] stat_commits_q;
  logic [31:0] stat_squashed_q;

  // Free-running event counters; wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_commits_q  <= '0;
      stat_squashed_q <= '0;
    end else begin
      if (commit_fire) begin
        stat_commits_q <= stat_commits_q + 32'd1;
      end
      if (state_q == StWalk) begin
        stat_squashed_q <= stat_squashed_q + 32'd1;
      end
    end
  end

  assign stat_commits_o  = stat_commits_q;
  assign stat_squashed_o = stat_squashed_q;
`endif

  assign alloc_tag_o       = tail_q;
  assign commit_valid_o    = commit_valid_q;
  assign commit_arch_rd_o  = commit_arch_q;
  assign commit_phys_o     = commit_phys_q;
  assign free_valid_o      = free_valid_q;
  assign free_phys_o       = free_phys_q;
  assign restore_valid_o   = restore_valid_q;
  assign restore_arch_rd_o = restore_arch_q;
  assign restore_phys_o    = restore_phys_q;
  assign recovering_o      = (state_q == StWalk);
  assign al_count_o        = count_q;

endmodule

// File: tb/tb_rename_commit_ctrl.sv
// Bench for rename_commit_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_rename_commit_ctrl;

  localparam int D = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_valid, alloc_ready, alloc_uses_rw;
  logic [4:0] alloc_arch_rd;
  logic [5:0] alloc_new_phys, alloc_old_phys;
  logic [4:0] alloc_tag;
  logic       wb_valid;
  logic [4:0] wb_tag;
  logic       flush_req;
  logic [4:0] flush_tag;
  logic       commit_valid;
  logic [4:0] commit_arch_rd;
  logic [5:0] commit_phys;
  logic       free_valid;
  logic [5:0] free_phys;
  logic       restore_valid;
  logic [4:0] restore_arch_rd;
  logic [5:0] restore_phys;
  logic       recovering;
  logic [5:0] al_count;
`ifdef RENAME_CMT_STATS_EN
  logic [31:0] stat_commits, stat_squashed;
`endif

  rename_commit_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_valid_i    (alloc_valid),
    .alloc_ready_o    (alloc_ready),
    .alloc_uses_rw_i  (alloc_uses_rw),
    .alloc_arch_rd_i  (alloc_arch_rd),
    .alloc_new_phys_i (alloc_new_phys),
    .alloc_old_phys_i (alloc_old_phys),
    .alloc_tag_o      (alloc_tag),
    .wb_valid_i       (wb_valid),
    .wb_tag_i         (wb_tag),
    .flush_req_i      (flush_req),
    .flush_tag_i      (flush_tag),
    .commit_valid_o   (commit_valid),
    .commit_arch_rd_o (commit_arch_rd),
    .commit_phys_o    (commit_phys),
    .free_valid_o     (free_valid),
    .free_phys_o      (free_phys),
    .restore_valid_o  (restore_valid),
    .restore_arch_rd_o(restore_arch_rd),
    .restore_phys_o   (restore_phys),
    .recovering_o     (recovering),
    .al_count_o       (al_count)
`ifdef RENAME_CMT_STATS_EN
    ,
    .stat_commits_o   (stat_commits),
    .stat_squashed_o  (stat_squashed)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int commits_seen = 0;

  // Model: active list as an ordered queue, oldest at the front.
  typedef struct {
    int tag;
    bit done;
    bit rw;
    int arch;
    int np;
    int op;
  } ent_t;

  ent_t al[$];
  int   mtail;
  bit   walking;
  int   ftag;
  bit   e_cv, e_fv, e_rv;
  int   e_carch, e_cphys, e_fphys, e_rarch, e_rphys;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    al.delete();
    mtail   = 0;
    walking = 1'b0;
    ftag    = 0;
    e_cv    = 1'b0;
    e_fv    = 1'b0;
    e_rv    = 1'b0;
  endfunction

  function automatic int find(int t);
    foreach (al[i]) if (al[i].tag == t) return i;
    return -1;
  endfunction

  // Compare every output against the model for the current cycle.
  function automatic void check_outputs();
    chk("alloc_ready", 32'(alloc_ready), 32'(!walking && al.size() < D && !flush_req));
    chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
    chk("al_count", 32'(al_count), 32'(al.size()));
    chk("recovering", 32'(recovering), 32'(walking));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    if (e_cv) begin
      commits_seen++;
      chk("commit_arch_rd", 32'(commit_arch_rd), 32'(e_carch));
      chk("commit_phys", 32'(commit_phys), 32'(e_cphys));
    end
    chk("free_valid", 32'(free_valid), 32'(e_fv));
    if (e_fv) chk("free_phys", 32'(free_phys), 32'(e_fphys));
    chk("restore_valid", 32'(restore_valid), 32'(e_rv));
    if (e_rv) begin
      chk("restore_arch_rd", 32'(restore_arch_rd), 32'(e_rarch));
      chk("restore_phys", 32'(restore_phys), 32'(e_rphys));
    end
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    int   wi, fi;
    bit   cm, acc, go;
    ent_t e;
    e_cv = 1'b0;
    e_fv = 1'b0;
    e_rv = 1'b0;
    wi = wb_valid ? find(int'(wb_tag)) : -1;
    if (!walking) begin
      cm  = (al.size() > 0) && al[0].done;
      acc = alloc_valid && (al.size() < D) && !flush_req;
      fi  = flush_req ? find(int'(flush_tag)) : -1;
      go  = (fi >= 0) && (al[al.size()-1].tag != int'(flush_tag));
      if (wi >= 0) al[wi].done = 1'b1;
      if (cm) begin
        e       = al.pop_front();
        e_cv    = 1'b1;
        e_carch = e.arch;
        e_cphys = e.np;
        e_fv    = e.rw;
        e_fphys = e.op;
      end
      if (acc) begin
        e.tag  = mtail;
        e.done = 1'b0;
        e.rw   = alloc_uses_rw;
        e.arch = int'(alloc_arch_rd);
        e.np   = int'(alloc_new_phys);
        e.op   = int'(alloc_old_phys);
        al.push_back(e);
        mtail = (mtail + 1) % D;
      end
      if (go) begin
        walking = 1'b1;
        ftag    = int'(flush_tag);
      end
    end else begin
      if (wi >= 0) al[wi].done = 1'b1;
      e       = al.pop_back();
      e_rv    = e.rw;
      e_rarch = e.arch;
      e_rphys = e.op;
      e_fv    = e.rw;
      e_fphys = e.np;
      if (e.tag == (ftag + 1) % D) begin
        walking = 1'b0;
        mtail   = e.tag;
      end
    end
  endfunction

  // Called just after a falling edge with inputs driven; returns at the next one.
  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid    = 1'b0;
    alloc_uses_rw  = 1'b0;
    alloc_arch_rd  = '0;
    alloc_new_phys = '0;
    alloc_old_phys = '0;
    wb_valid       = 1'b0;
    wb_tag         = '0;
    flush_req      = 1'b0;
    flush_tag      = '0;
  endtask

  task automatic drive_alloc(bit rw, int arch, int np, int op);
    idle();
    alloc_valid    = 1'b1;
    alloc_uses_rw  = rw;
    alloc_arch_rd  = 5'(arch);
    alloc_new_phys = 6'(np);
    alloc_old_phys = 6'(op);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic alloc_five();
    for (int i = 0; i < 5; i++) begin
      drive_alloc(1'b1, i + 1, 40 + i, 10 + i);
      tick();
    end
  endtask

  int base;

  initial begin
    idle();
    do_reset();

    // Reset state
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_al_count", 32'(al_count), 32'd0);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_pulses", 32'({commit_valid, free_valid, restore_valid}), 32'd0);
    chk("rst_recovering", 32'(recovering), 32'd0);

    // Out-of-order writeback, in-order commit
    drive_alloc(1'b1, 1, 33, 1); tick();
    drive_alloc(1'b1, 2, 34, 2); tick();
    drive_alloc(1'b1, 3, 35, 3); tick();
    idle(); wb_valid = 1'b1; wb_tag = 5'd1; tick();
    idle(); wb_valid = 1'b1; wb_tag = 5'd0; tick();
    idle(); tick();
    chk("c2_commit0_valid", 32'(commit_valid), 32'd1);
    chk("c2_commit0_phys", 32'(commit_phys), 32'd33);
    chk("c2_free0", 32'(free_phys), 32'd1);
    tick();
    chk("c2_commit1_valid", 32'(commit_valid), 32'd1);
    chk("c2_free1", 32'(free_phys), 32'd2);
    chk("c2_count", 32'(al_count), 32'd1);
    tick();
    chk("c2_no_more_commit", 32'(commit_valid), 32'd0);

    // Fill to capacity, then retire one
    do_reset();
    for (int i = 0; i < D; i++) begin
      drive_alloc(1'b1, i, i, i + 32);
      tick();
    end
    idle();
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(al_count), 32'd32);
    wb_valid = 1'b1; wb_tag = 5'd0; tick();
    idle(); tick();
    chk("full_commit", 32'(commit_valid), 32'd1);
    chk("full_ready_after", 32'(alloc_ready), 32'd1);
    chk("full_tag_after", 32'(alloc_tag), 32'd0);
    chk("full_count_after", 32'(al_count), 32'd31);

    // Mispredict walk over tags 4,3,2
    do_reset();
    alloc_five();
    idle(); flush_req = 1'b1; flush_tag = 5'd1; alloc_valid = 1'b1;
    #1;
    chk("flush_blocks_alloc", 32'(alloc_ready), 32'd0);
    tick();
    idle();
    chk("w1_recovering", 32'(recovering), 32'd1);
    chk("w1_restore", 32'(restore_valid), 32'd0);
    tick();
    chk("w2_recovering", 32'(recovering), 32'd1);
    chk("w2_restore", 32'({restore_valid, restore_arch_rd, restore_phys}), {20'd0, 1'b1, 5'd5, 6'd14});
    chk("w2_free", 32'(free_phys), 32'd44);
    tick();
    chk("w3_restore_phys", 32'(restore_phys), 32'd13);
    chk("w3_free", 32'(free_phys), 32'd43);
    tick();
    chk("w4_recovering", 32'(recovering), 32'd0);
    chk("w4_restore_phys", 32'(restore_phys), 32'd12);
    chk("w4_free", 32'(free_phys), 32'd42);
    chk("w4_alloc_tag", 32'(alloc_tag), 32'd2);
    chk("w4_count", 32'(al_count), 32'd2);
    tick();
    chk("w5_restore", 32'(restore_valid), 32'd0);

    // Streaming alloc+wb across the wrap point
    do_reset();
    base = commits_seen;
    for (int i = 0; i < 40; i++) begin
      drive_alloc(1'b1, i % 32, i % 64, (i + 7) % 64);
      wb_valid = (i > 0);
      wb_tag   = 5'((i + 31) % 32);
      tick();
    end
    idle(); wb_valid = 1'b1; wb_tag = 5'd7; tick();
    idle();
    repeat (4) tick();
    chk("stream_commits", 32'(commits_seen - base), 32'd40);
    chk("stream_tag", 32'(alloc_tag), 32'd8);
    chk("stream_count", 32'(al_count), 32'd0);

    // Asynchronous reset in the middle of a walk
    do_reset();
    alloc_five();
    idle(); flush_req = 1'b1; flush_tag = 5'd0; tick();
    idle(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_recovering", 32'(recovering), 32'd0);
    chk("arst_pulses", 32'({commit_valid, free_valid, restore_valid}), 32'd0);
    chk("arst_count", 32'(al_count), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_alloc(1'b1, 7, 9, 3); tick();
    idle(); wb_valid = 1'b1; wb_tag = 5'd0; tick();
    idle(); tick();
    chk("arst_resume_commit", 32'({commit_valid, commit_phys}), {25'd0, 1'b1, 6'd9});
    chk("arst_resume_free", 32'(free_phys), 32'd3);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      alloc_valid    = ($urandom_range(0, 9) < 7);
      alloc_uses_rw  = ($urandom_range(0, 3) != 0);
      alloc_arch_rd  = 5'($urandom);
      alloc_new_phys = 6'($urandom);
      alloc_old_phys = 6'($urandom);
      wb_valid       = $urandom_range(0, 1) == 1;
      if (al.size() > 0 && $urandom_range(0, 3) != 0)
        wb_tag = 5'(al[$urandom_range(0, al.size() - 1)].tag);
      else
        wb_tag = 5'($urandom);
      flush_req = ($urandom_range(0, 29) == 0);
      if (al.size() > 0 && $urandom_range(0, 3) != 0)
        flush_tag = 5'(al[$urandom_range(0, al.size() - 1)].tag);
      else
        flush_tag = 5'($urandom);
      tick();
    end
    idle();
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
